axi_slave_mem: RTL and testbench

- Parametrised AXI4 slave memory responder; next generation of the instruction/data slave BFMs that sit beside core in core-level benches.
- Serves INCR bursts on independent read and write channels.
- Configurable data width, depth and read latency.
- Storage array `ram_array` is hierarchically accessible so benches can preload and inspect it.

---
 rtl/axi_mem_pkg.sv | 28 ++
 rtl/axi_mem_rd_ctrl.sv | 82 ++++++++
 rtl/axi_slave_mem.sv | 152 +++++++++++++++
 tb/tb_axi_slave_mem.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/axi_mem_pkg.sv
// Shared response codes, FSM state encodings and a constant log2 helper for axi_slave_mem.
package axi_mem_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } w_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_DATA
    } r_state_t;

    // Smallest n with 2**n >= value; used to turn byte addresses into word indices.
    function automatic int clog2(input int value);
        int result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/axi_mem_rd_ctrl.sv
// Read-channel controller for axi_slave_mem: AR acceptance, latency countdown and
// beat sequencing. The memory itself lives in the top; this block only supplies the index.
module axi_mem_rd_ctrl
    import axi_mem_pkg::*;
#(
    parameter int C_IDX_WIDTH  = 11,
    parameter int C_RD_LATENCY = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [C_IDX_WIDTH-1:0] ar_idx,
    input  logic [7:0]             ar_len,
    input  logic                   ar_oor,
    input  logic                   ar_valid,
    output logic                   ar_ready,
    input  logic                   r_ready,
    output logic                   r_valid,
    output logic                   r_last,
    output logic                   r_err,
    output logic [C_IDX_WIDTH-1:0] rd_idx
);

    localparam logic [3:0] LAT = 4'(C_RD_LATENCY);

    r_state_t   state, state_next;
    logic [7:0] cnt;
    logic [3:0] lat_cnt;
    logic       ar_hs, r_hs;

    assign ar_hs = ar_valid && ar_ready;
    assign r_hs  = r_valid && r_ready;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= R_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        state_next = state;
        ar_ready   = 1'b0;
        r_valid    = 1'b0;
        r_last     = 1'b0;
        unique case (state)
            R_IDLE: begin
                ar_ready = 1'b1;
                if (ar_valid) state_next = (LAT == 4'd0) ? R_DATA : R_WAIT;
            end
            R_WAIT: begin
                if (lat_cnt == 4'd1) state_next = R_DATA;
            end
            R_DATA: begin
                r_valid = 1'b1;
                r_last  = (cnt == 8'd0);
                if (r_ready && cnt == 8'd0) state_next = R_IDLE;
            end
            default: state_next = R_IDLE;
        endcase
    end

    // Index wraps naturally at the array size because it is exactly C_IDX_WIDTH bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_idx  <= '0;
            cnt     <= '0;
            lat_cnt <= '0;
            r_err   <= 1'b0;
        end else if (ar_hs) begin
            rd_idx  <= ar_idx;
            cnt     <= ar_len;
            lat_cnt <= LAT;
            r_err   <= ar_oor;
        end else if (state == R_WAIT) begin
            lat_cnt <= lat_cnt - 4'd1;
        end else if (r_hs && cnt != 8'd0) begin
            rd_idx <= rd_idx + C_IDX_WIDTH'(1);
            cnt    <= cnt - 8'd1;
        end
    end

endmodule

// File: rtl/axi_slave_mem.sv
// AXI4 INCR-burst slave memory with independent read/write channels and a preloadable ram_array.
// Optional macro AXI_MEM_OOR_ERR_EN flags bursts that run past the array end with SLVERR.
module axi_slave_mem
    import axi_mem_pkg::*;
#(
    parameter int C_AXI_DATA_WIDTH = 32,
    parameter int C_OFFSET_WIDTH   = 28,
    parameter int C_DEPTH_WORDS    = 2048,
    parameter int C_RD_LATENCY     = 2
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [C_OFFSET_WIDTH-1:0]     AWADDR,
    input  logic [7:0]                    AWLEN,
    input  logic                          AWVALID,
    output logic                          AWREADY,
    input  logic [C_AXI_DATA_WIDTH-1:0]   WDATA,
    input  logic [C_AXI_DATA_WIDTH/8-1:0] WSTRB,
    input  logic                          WLAST,
    input  logic                          WVALID,
    output logic                          WREADY,
    output logic [1:0]                    BRESP,
    output logic                          BVALID,
    input  logic                          BREADY,
    input  logic [C_OFFSET_WIDTH-1:0]     ARADDR,
    input  logic [7:0]                    ARLEN,
    input  logic                          ARVALID,
    output logic                          ARREADY,
    output logic [C_AXI_DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]                    RRESP,
    output logic                          RLAST,
    output logic                          RVALID,
    input  logic                          RREADY
);

    localparam int BYTES = C_AXI_DATA_WIDTH / 8;
    localparam int SHIFT = clog2(BYTES);
    localparam int IDX_W = clog2(C_DEPTH_WORDS);

    logic [C_AXI_DATA_WIDTH-1:0] ram_array [C_DEPTH_WORDS];

    logic [C_OFFSET_WIDTH-1:0] aw_word, ar_word;
    logic                      aw_oor, ar_oor;

    assign aw_word = AWADDR >> SHIFT;
    assign ar_word = ARADDR >> SHIFT;

`ifdef AXI_MEM_OOR_ERR_EN
    // Start-or-end past the array: start_word + len >= depth covers both cases.
    localparam logic [C_OFFSET_WIDTH:0] DEPTH_LIM = (C_OFFSET_WIDTH + 1)'(C_DEPTH_WORDS);
    assign aw_oor = ({1'b0, aw_word} + (C_OFFSET_WIDTH + 1)'(AWLEN)) >= DEPTH_LIM;
    assign ar_oor = ({1'b0, ar_word} + (C_OFFSET_WIDTH + 1)'(ARLEN)) >= DEPTH_LIM;
`else
    logic unused_addr_hi;
    assign unused_addr_hi = ^{aw_word[C_OFFSET_WIDTH-1:IDX_W], ar_word[C_OFFSET_WIDTH-1:IDX_W]};
    assign aw_oor = 1'b0;
    assign ar_oor = 1'b0;
`endif

    // ---------------- write channel ----------------
    w_state_t         w_state, w_state_next;
    logic [IDX_W-1:0] w_idx;
    logic [7:0]       w_cnt;
    logic             w_oor;
    logic [1:0]       bresp_q;
    logic             aw_hs, w_hs;

    assign aw_hs = AWVALID && AWREADY;
    assign w_hs  = WVALID && WREADY;
    assign BRESP = bresp_q;

    always_ff @(posedge CLK) begin
        if (RST) w_state <= W_IDLE;
        else     w_state <= w_state_next;
    end

    always_comb begin
        w_state_next = w_state;
        AWREADY      = 1'b0;
        WREADY       = 1'b0;
        BVALID       = 1'b0;
        unique case (w_state)
            W_IDLE: begin
                AWREADY = 1'b1;
                if (AWVALID) w_state_next = W_DATA;
            end
            W_DATA: begin
                WREADY = 1'b1;
                if (WVALID && w_cnt == 8'd0) w_state_next = W_RESP;
            end
            W_RESP: begin
                BVALID = 1'b1;
                if (BREADY) w_state_next = W_IDLE;
            end
            default: w_state_next = W_IDLE;
        endcase
    end

    // The beat count, not WLAST, ends the burst; a disagreeing WLAST only poisons BRESP.
    always_ff @(posedge CLK) begin
        if (RST) begin
            w_idx   <= '0;
            w_cnt   <= '0;
            w_oor   <= 1'b0;
            bresp_q <= RESP_OKAY;
        end else if (aw_hs) begin
            w_idx   <= aw_word[IDX_W-1:0];
            w_cnt   <= AWLEN;
            w_oor   <= aw_oor;
            bresp_q <= aw_oor ? RESP_SLVERR : RESP_OKAY;
        end else if (w_hs) begin
            w_idx <= w_idx + IDX_W'(1);
            w_cnt <= w_cnt - 8'd1;
            if (WLAST != (w_cnt == 8'd0)) bresp_q <= RESP_SLVERR;
        end
    end

    // NOTE: the storage array is deliberately not reset; contents survive RST so benches can preload.
    always_ff @(posedge CLK) begin
        if (w_hs && !w_oor && !RST) begin
            for (int b = 0; b < BYTES; b++) begin
                if (WSTRB[b]) ram_array[w_idx][b*8 +: 8] <= WDATA[b*8 +: 8];
            end
        end
    end

    // ---------------- read channel ----------------
    logic [IDX_W-1:0] rd_idx;
    logic             r_err;

    axi_mem_rd_ctrl #(
        .C_IDX_WIDTH  (IDX_W),
        .C_RD_LATENCY (C_RD_LATENCY)
    ) u_rd_ctrl (
        .clk      (CLK),
        .rst      (RST),
        .ar_idx   (ar_word[IDX_W-1:0]),
        .ar_len   (ARLEN),
        .ar_oor   (ar_oor),
        .ar_valid (ARVALID),
        .ar_ready (ARREADY),
        .r_ready  (RREADY),
        .r_valid  (RVALID),
        .r_last   (RLAST),
        .r_err    (r_err),
        .rd_idx   (rd_idx)
    );

    assign RDATA = (RVALID && !r_err) ? ram_array[rd_idx] : '0;
    assign RRESP = (RVALID && r_err) ? RESP_SLVERR : RESP_OKAY;

endmodule

// File: tb/tb_axi_slave_mem.sv
// Directed self-checking bench for axi_slave_mem (32-bit, 2048 words, read latency 2).
`timescale 1ns/1ps
module tb_axi_slave_mem;
    import axi_mem_pkg::*;

    localparam int DW    = 32;
    localparam int AW    = 28;
    localparam int DEPTH = 2048;

    logic          CLK = 1'b0;
    logic          RST;
    logic [AW-1:0] AWADDR, ARADDR;
    logic [7:0]    AWLEN, ARLEN;
    logic          AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
    logic [DW-1:0] WDATA, RDATA;
    logic [3:0]    WSTRB;
    logic [1:0]    BRESP, RRESP;
    logic          ARVALID, ARREADY, RLAST, RVALID, RREADY;

    always #5 CLK = ~CLK;

    axi_slave_mem #(
        .C_AXI_DATA_WIDTH (DW),
        .C_OFFSET_WIDTH   (AW),
        .C_DEPTH_WORDS    (DEPTH),
        .C_RD_LATENCY     (2)
    ) dut (
        .CLK (CLK), .RST (RST),
        .AWADDR (AWADDR), .AWLEN (AWLEN), .AWVALID (AWVALID), .AWREADY (AWREADY),
        .WDATA (WDATA), .WSTRB (WSTRB), .WLAST (WLAST), .WVALID (WVALID), .WREADY (WREADY),
        .BRESP (BRESP), .BVALID (BVALID), .BREADY (BREADY),
        .ARADDR (ARADDR), .ARLEN (ARLEN), .ARVALID (ARVALID), .ARREADY (ARREADY),
        .RDATA (RDATA), .RRESP (RRESP), .RLAST (RLAST), .RVALID (RVALID), .RREADY (RREADY)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] rd_data [16];
    logic [1:0]  rd_resp [16];
    logic        rd_last [16];
    int          rd_lat;
    logic [1:0]  wr_resp;
    int          seen;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drives one write burst; beat b carries base+b, WLAST is raised on beat last_beat.
    task automatic axi_write(input logic [AW-1:0] addr, input int len, input logic [31:0] base,
                             input logic [3:0] strb, input int last_beat);
        bit ok;
        bit all_ok = 1'b1;
        @(negedge CLK);
        AWADDR = addr; AWLEN = 8'(len); AWVALID = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 50 && !ok; t++) begin ok = AWREADY; @(negedge CLK); end
        AWVALID = 1'b0;
        all_ok &= ok;
        for (int b = 0; b <= len; b++) begin
            WDATA = base + 32'(b); WSTRB = strb; WLAST = (b == last_beat); WVALID = 1'b1;
            ok = 1'b0;
            for (int t = 0; t < 50 && !ok; t++) begin ok = WREADY; @(negedge CLK); end
            all_ok &= ok;
        end
        WVALID = 1'b0; WLAST = 1'b0;
        BREADY = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 50 && !ok; t++) begin
            ok = BVALID;
            if (ok) wr_resp = BRESP;
            @(negedge CLK);
        end
        BREADY = 1'b0;
        all_ok &= ok;
        check("wr_handshakes", all_ok, 1'b1);
    endtask

    // Issues one read burst; with toggle set RREADY alternates 1,0,1,0 over valid cycles.
    task automatic axi_read(input logic [AW-1:0] addr, input int len, input bit toggle);
        bit          ok;
        int          beat = 0;
        int          k = 0;
        bit          stalled = 1'b0;
        logic [31:0] held = '0;
        @(negedge CLK);
        ARADDR = addr; ARLEN = 8'(len); ARVALID = 1'b1; RREADY = 1'b0;
        ok = 1'b0;
        for (int t = 0; t < 50 && !ok; t++) begin ok = ARREADY; @(negedge CLK); end
        ARVALID = 1'b0;
        check("ar_handshake", ok, 1'b1);
        rd_lat = 0;
        for (int t = 0; t < 50 && !RVALID; t++) begin @(negedge CLK); rd_lat++; end
        for (int t = 0; t < 200 && beat <= len; t++) begin
            if (RVALID) begin
                if (stalled) check("r_hold", RDATA, held);
                RREADY = toggle ? ((k % 2) == 0) : 1'b1;
                k++;
                if (RREADY) begin
                    rd_data[beat] = RDATA; rd_resp[beat] = RRESP; rd_last[beat] = RLAST;
                    beat++; stalled = 1'b0;
                end else begin
                    held = RDATA; stalled = 1'b1;
                end
            end
            @(negedge CLK);
        end
        RREADY = 1'b0;
        check("r_beat_count", beat, len + 1);
    endtask

    initial begin
        #300us;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1;
        AWADDR = '0; AWLEN = '0; AWVALID = 1'b0; WDATA = '0; WSTRB = '0; WLAST = 1'b0;
        WVALID = 1'b0; BREADY = 1'b0; ARADDR = '0; ARLEN = '0; ARVALID = 1'b0; RREADY = 1'b0;
        repeat (2) @(negedge CLK);
        RST = 1'b0;

        check("rst_awready", AWREADY, 1'b1);
        check("rst_arready", ARREADY, 1'b1);
        check("rst_wready",  WREADY,  1'b0);
        check("rst_bvalid",  BVALID,  1'b0);
        check("rst_rvalid",  RVALID,  1'b0);
        check("rst_rlast",   RLAST,   1'b0);
        check("rst_rdata",   RDATA,   32'h0);
        check("rst_bresp",   BRESP,   2'b00);
        check("rst_rresp",   RRESP,   2'b00);

        // Single write then read with latency 2.
        axi_write(28'h10, 0, 32'hDEADBEEF, 4'hF, 0);
        check("single_bresp", wr_resp, RESP_OKAY);
        axi_read(28'h10, 0, 1'b0);
        check("single_latency", rd_lat, 2);
        check("single_rdata", rd_data[0], 32'hDEADBEEF);
        check("single_rlast", rd_last[0], 1'b1);
        check("single_rresp", rd_resp[0], RESP_OKAY);

        // Preload word i with value i through eight 256-beat bursts.
        for (int k = 0; k < DEPTH / 256; k++) begin
            axi_write(AW'(k * 256 * 4), 255, 32'(k * 256), 4'hF, 255);
            check("preload_bresp", wr_resp, RESP_OKAY);
        end

        // 8-beat burst with RREADY toggling.
        axi_read(28'h0, 7, 1'b1);
        for (int i = 0; i < 8; i++) check("burst_rdata", rd_data[i], 32'(i));
        check("burst_rlast_first", rd_last[0], 1'b0);
        check("burst_rlast_end", rd_last[7], 1'b1);
        check("burst_arready_after", ARREADY, 1'b1);

        // Partial strobe over 0x11223344.
        axi_write(28'h100, 0, 32'h11223344, 4'hF, 0);
        axi_write(28'h100, 0, 32'hAABBCCDD, 4'b0101, 0);
        check("strobe_bresp", wr_resp, RESP_OKAY);
        axi_read(28'h100, 0, 1'b0);
        check("strobe_rdata", rd_data[0], 32'h11BB33DD);

        // Burst crossing the end of the array.
        axi_read(AW'(2047 * 4), 1, 1'b0);
`ifdef AXI_MEM_OOR_ERR_EN
        check("wrap_rdata0", rd_data[0], 32'h0);
        check("wrap_rdata1", rd_data[1], 32'h0);
        check("wrap_rresp0", rd_resp[0], RESP_SLVERR);
        check("wrap_rresp1", rd_resp[1], RESP_SLVERR);
        axi_write(AW'(2047 * 4), 1, 32'h55555555, 4'hF, 1);
        check("oor_wr_bresp", wr_resp, RESP_SLVERR);
        axi_read(AW'(2047 * 4), 0, 1'b0);
        check("oor_wr_untouched", rd_data[0], 32'd2047);
`else
        check("wrap_rdata0", rd_data[0], 32'd2047);
        check("wrap_rdata1", rd_data[1], 32'd0);
        check("wrap_rresp0", rd_resp[0], RESP_OKAY);
        check("wrap_rresp1", rd_resp[1], RESP_OKAY);
`endif

        // WLAST on the second beat of a 4-beat burst.
        axi_write(28'h200, 3, 32'hA0000000, 4'hF, 1);
        check("wlast_bresp", wr_resp, RESP_SLVERR);
        axi_read(28'h200, 3, 1'b0);
        for (int i = 0; i < 4; i++) check("wlast_rdata", rd_data[i], 32'hA0000000 + 32'(i));

        // Reset while the third beat of an 8-beat read is presented.
        @(negedge CLK);
        ARADDR = '0; ARLEN = 8'd7; ARVALID = 1'b1; RREADY = 1'b1;
        @(negedge CLK);
        ARVALID = 1'b0;
        seen = 0;
        for (int t = 0; t < 50; t++) begin
            if (RVALID) seen++;
            if (seen == 3) break;
            @(negedge CLK);
        end
        check("rst_mid_beat3", RDATA, 32'd2);
        RST = 1'b1; RREADY = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        check("rst_mid_rvalid", RVALID, 1'b0);
        check("rst_mid_arready", ARREADY, 1'b1);
        axi_read(28'h40, 1, 1'b0);
        check("post_rst_rdata0", rd_data[0], 32'd16);
        check("post_rst_rdata1", rd_data[1], 32'd17);
        check("post_rst_rlast", rd_last[1], 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
